mmio_port_bridge: RTL and testbench

- Memory-mapped I/O slave on the MEM-stage bus: EX/MEM ALU result as address, EX/MEM write data, and the MemRead/MemWrite controls, in parallel with the data RAM.
- Drives the processor's PortOut, synchronises PortIn, and provides a cycle timer with compare, sticky status flags and an interrupt line.
- The top level selects ReadData over RAM data when IOSelect is high, before the MEM/WB register.

---
 rtl/mmio_port_bridge_pkg.sv | 23 ++
 rtl/mmio_port_bridge_input_sync.sv | 35 +++
 rtl/mmio_port_bridge.sv | 131 +++++++++++++
 tb/tb_mmio_port_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_port_bridge_pkg.sv
// rtl/mmio_port_bridge_pkg.sv - shared register map and bit indices for the MMIO port bridge
package mmio_port_bridge_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

    localparam logic [7:0] OFF_OUT    = 8'h00;
    localparam logic [7:0] OFF_IN     = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_TCNT   = 8'h0C;
    localparam logic [7:0] OFF_TCMP   = 8'h10;
    localparam logic [7:0] OFF_CTRL   = 8'h14;

    localparam int STATUS_W     = 2;
    localparam int ST_IN_CHG    = 0;
    localparam int ST_TMR_MATCH = 1;

    localparam int CTRL_W       = 4;
    localparam int CTRL_TEN     = 0;
    localparam int CTRL_AUTOCLR = 1;
    localparam int CTRL_IE_CHG  = 2;
    localparam int CTRL_IE_TMR  = 3;

endpackage

// File: rtl/mmio_port_bridge_input_sync.sv
// rtl/mmio_port_bridge_input_sync.sv - multi-stage input synchroniser with change pulse
module io_input_synchronizer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic             change
);

    logic [WIDTH-1:0] stages [DEPTH];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
            prev <= '0;
        end else begin
            stages[0] <= async_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
            prev <= stages[DEPTH-1];
        end
    end

    assign sync_out = stages[DEPTH-1];
    // High for exactly one cycle after each new synchronised value appears.
    assign change   = (sync_out != prev);

endmodule

// File: rtl/mmio_port_bridge.sv
// rtl/mmio_port_bridge.sv - MEM-stage MMIO slave: output port, synchronised input, timer, irq
module mmio_port_bridge
    import mmio_port_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          IN_WIDTH    = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                IOSelect,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    logic                hit;
    logic                wr_en;
    logic                rd_en;
    logic [7:0]          offset;
    logic                unused_addr_bits;

    logic [IN_WIDTH-1:0] in_sync;
    logic                in_change;

    logic [31:0]         tcnt;
    logic [31:0]         tcnt_next;
    logic [31:0]         tcmp;
    logic [CTRL_W-1:0]   ctrl;
    logic [STATUS_W-1:0] status;
    logic [STATUS_W-1:0] status_set;
    logic [STATUS_W-1:0] status_clr;
    logic [STATUS_W-1:0] status_next;
    logic                timer_match;

    logic wr_out, wr_status, wr_tcnt, wr_tcmp, wr_ctrl;

    // Byte lane bits are not decoded; any byte address inside a word hits that word.
    assign hit              = (Address[31:8] == BASE_ADDR[31:8]);
    assign offset           = {Address[7:2], 2'b00};
    assign unused_addr_bits = ^Address[1:0];
    assign IOSelect         = hit & (MemRead | MemWrite);
    assign wr_en            = hit & MemWrite;
    assign rd_en            = hit & MemRead;

    assign wr_out    = wr_en && (offset == OFF_OUT);
    assign wr_status = wr_en && (offset == OFF_STATUS);
    assign wr_tcnt   = wr_en && (offset == OFF_TCNT);
    assign wr_tcmp   = wr_en && (offset == OFF_TCMP);
    assign wr_ctrl   = wr_en && (offset == OFF_CTRL);

    io_input_synchronizer #(
        .WIDTH (IN_WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_in_sync (
        .clk      (clk),
        .rst_n    (reset),
        .async_in (PortIn),
        .sync_out (in_sync),
        .change   (in_change)
    );

    assign timer_match = ctrl[CTRL_TEN] & (tcnt == tcmp);

    // Software write beats the auto-clear reload, which beats counting.
    always_comb begin
        tcnt_next = tcnt;
        if (wr_tcnt) begin
            tcnt_next = WriteData;
        end else if (timer_match && ctrl[CTRL_AUTOCLR]) begin
            tcnt_next = '0;
        end else if (ctrl[CTRL_TEN]) begin
            tcnt_next = tcnt + 32'd1;
        end
    end

    // Set conditions win over a same-cycle write-1-to-clear.
    always_comb begin
        status_set               = '0;
        status_set[ST_IN_CHG]    = in_change;
        status_set[ST_TMR_MATCH] = timer_match;
        status_clr               = wr_status ? WriteData[STATUS_W-1:0] : '0;
        status_next              = status_set | (status & ~status_clr);
    end

    always_comb begin
        ReadData = '0;
        if (rd_en) begin
            case (offset)
                OFF_OUT:    ReadData = PortOut;
                OFF_IN:     ReadData = 32'(in_sync);
                OFF_STATUS: ReadData = 32'(status);
                OFF_TCNT:   ReadData = tcnt;
                OFF_TCMP:   ReadData = tcmp;
                OFF_CTRL:   ReadData = 32'(ctrl);
                default:    ReadData = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PortOut <= '0;
            tcnt    <= '0;
            tcmp    <= '0;
            ctrl    <= '0;
            status  <= '0;
            Irq     <= 1'b0;
        end else begin
            if (wr_out) begin
                PortOut <= WriteData;
            end
            if (wr_tcmp) begin
                tcmp <= WriteData;
            end
            if (wr_ctrl) begin
                ctrl <= WriteData[CTRL_W-1:0];
            end
            tcnt   <= tcnt_next;
            status <= status_next;
            Irq    <= (status[ST_IN_CHG] & ctrl[CTRL_IE_CHG]) |
                      (status[ST_TMR_MATCH] & ctrl[CTRL_IE_TMR]);
        end
    end

endmodule

// File: tb/tb_mmio_port_bridge.sv
// tb/tb_mmio_port_bridge.sv - self-checking bench for mmio_port_bridge
module tb_mmio_port_bridge;

    localparam logic [31:0] A_OUT    = 32'hFFFF_0000;
    localparam logic [31:0] A_IN     = 32'hFFFF_0004;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
    localparam logic [31:0] A_TCNT   = 32'hFFFF_000C;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_0010;
    localparam logic [31:0] A_CTRL   = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        IOSelect;
    logic [31:0] PortOut;
    logic        Irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rd;
        logic [31:0] exp_port;
    } vec_t;
    vec_t vecs[9];

    always #5 clk = ~clk;

    mmio_port_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .IOSelect  (IOSelect),
        .PortOut   (PortOut),
        .Irq       (Irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a read now, queue its expectation, then compare once the combinational path settles.
    task automatic expect_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
        sb_t e;
        sb_t got;
        Address   = addr;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        e.name    = name;
        e.exp     = exp;
        sb_q.push_back(e);
        #1;
        got = sb_q.pop_front();
        check(got.name, ReadData, got.exp);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        PortIn   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_tcnt(input string name, input logic [31:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            Address  = A_TCNT;
            MemRead  = 1'b1;
            MemWrite = 1'b0;
            #1;
            if (ReadData == v) ok = 1'b1;
        end
        check(name, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hFFFF_0000, 32'h0000_00A5, A_OUT,  32'h0000_00A5, 32'h0000_00A5};
        vecs[1] = '{32'hFFFF_0003, 32'h1234_5678, A_OUT,  32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{A_TCMP,        32'hDEAD_BEEF, A_TCMP, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3] = '{A_CTRL,        32'hFFFF_FFF4, A_CTRL, 32'h0000_0004, 32'h1234_5678};
        vecs[4] = '{32'hFFFF_0020, 32'h0000_1234, 32'hFFFF_0020, 32'h0, 32'h1234_5678};
        vecs[5] = '{A_IN,          32'hFFFF_FFFF, A_IN,   32'h0000_0000, 32'h1234_5678};
        vecs[6] = '{32'h1001_0000, 32'h0000_0000, A_OUT,  32'h1234_5678, 32'h1234_5678};
        vecs[7] = '{A_TCNT,        32'h0000_0100, A_TCNT, 32'h0000_0100, 32'h1234_5678};
        vecs[8] = '{A_STATUS,      32'h0000_0003, A_STATUS, 32'h0000_0000, 32'h1234_5678};

        Address   = '0;
        WriteData = '0;
        reset     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        PortIn    = 8'h00;
        #1;
        check("reset_portout", PortOut, 32'h0);
        check("reset_irq", {31'b0, Irq}, 32'h0);
        do_reset();
        expect_read("rst_out",    A_OUT,    32'h0);
        expect_read("rst_status", A_STATUS, 32'h0);
        expect_read("rst_tcnt",   A_TCNT,   32'h0);
        expect_read("rst_tcmp",   A_TCMP,   32'h0);
        expect_read("rst_ctrl",   A_CTRL,   32'h0);

        // Register map write/readback table.
        for (int i = 0; i < 9; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdata);
            @(negedge clk);
            check($sformatf("vec%0d_portout", i), PortOut, vecs[i].exp_port);
            expect_read($sformatf("vec%0d_read", i), vecs[i].raddr, vecs[i].exp_rd);
            check($sformatf("vec%0d_iosel", i), {31'b0, IOSelect}, 32'h1);
            check($sformatf("vec%0d_irq", i), {31'b0, Irq}, 32'h0);
        end

        // Asynchronous reset mid-cycle clears PortOut without an edge.
        @(negedge clk);
        MemRead = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_portout", PortOut, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Miss, and read-during-write returning the pre-write value.
        bus_write(A_OUT, 32'h0000_005A);
        @(negedge clk);
        Address   = 32'h1001_0000;
        WriteData = 32'hFFFF_FFFF;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        #1;
        check("miss_iosel", {31'b0, IOSelect}, 32'h0);
        check("miss_rdata", ReadData, 32'h0);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        check("miss_portout", PortOut, 32'h0000_005A);
        Address   = A_OUT;
        WriteData = 32'h0000_0077;
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        #1;
        check("rdw_prewrite", ReadData, 32'h0000_005A);
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        expect_read("rdw_postwrite", A_OUT, 32'h0000_0077);

        // PortIn synchroniser latency and IN_CHG.
        do_reset();
        @(negedge clk);
        PortIn = 8'h3C;
        expect_read("in_cycle0", A_IN, 32'h0);
        @(negedge clk);
        expect_read("in_cycle1", A_IN, 32'h0);
        @(negedge clk);
        expect_read("in_cycle2", A_IN, 32'h0000_003C);
        expect_read("chg_not_yet", A_STATUS, 32'h0);
        @(negedge clk);
        expect_read("chg_set", A_STATUS, 32'h1);
        bus_write(A_STATUS, 32'h1);
        @(negedge clk);
        expect_read("chg_w1c", A_STATUS, 32'h0);
        PortIn  = 8'h00;
        MemRead = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Address   = A_STATUS;
        WriteData = 32'h1;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        expect_read("chg_set_wins", A_STATUS, 32'h1);

        // Timer compare with auto-clear and interrupt.
        do_reset();
        bus_write(A_TCMP, 32'd5);
        bus_write(A_CTRL, 32'hB);
        wait_tcnt("tmr_reach5", 32'd5);
        expect_read("tmr_flag_pre", A_STATUS, 32'h0);
        check("tmr_irq_pre", {31'b0, Irq}, 32'h0);
        @(negedge clk);
        expect_read("tmr_autoclr", A_TCNT, 32'h0);
        expect_read("tmr_flag", A_STATUS, 32'h2);
        check("tmr_irq_lag", {31'b0, Irq}, 32'h0);
        @(negedge clk);
        check("tmr_irq", {31'b0, Irq}, 32'h1);
        expect_read("tmr_after", A_TCNT, 32'h1);

        // Counter wrap.
        do_reset();
        bus_write(A_CTRL, 32'h1);
        bus_write(A_TCNT, 32'hFFFF_FFFE);
        @(negedge clk);
        expect_read("wrap0", A_TCNT, 32'hFFFF_FFFE);
        @(negedge clk);
        expect_read("wrap1", A_TCNT, 32'hFFFF_FFFF);
        @(negedge clk);
        expect_read("wrap2", A_TCNT, 32'h0);
        @(negedge clk);
        expect_read("wrap3", A_TCNT, 32'h1);

        // Software TCNT write colliding with an auto-clear match.
        do_reset();
        bus_write(A_TCMP, 32'd3);
        bus_write(A_CTRL, 32'h3);
        wait_tcnt("coll_reach3", 32'd3);
        Address   = A_TCNT;
        WriteData = 32'h0000_0055;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        expect_read("coll_write_wins", A_TCNT, 32'h0000_0055);
        expect_read("coll_flag", A_STATUS, 32'h2);
        @(negedge clk);
        expect_read("coll_next", A_TCNT, 32'h0000_0056);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
